msx_cart_bus_if: RTL and testbench
==================================

Name: msx_cart_bus_if

Overview:
- Slave front-end between the MSX cartridge connector pins and the internal I/O bus feeding the VDP/video core.
- Synchronises the asynchronous MSX strobes into the `clk` domain and turns each MSX I/O write or read into exactly one internal request with a valid/ready handshake.
- On reads, drives the read data back onto the MSX data bus and can hold the MSX in wait until the data is available.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on n_ce/n_wr/n_rd; legal range 2..3.
- RD_TIMEOUT, 63: clk cycles allowed in RD_WAIT before the read is forced to complete; legal range 1..255.

Ports:
- clk  in  1  system clock; single clock domain.
- n_reset  in  1  asynchronous active-low reset.
- n_ce  in  1  MSX chip enable, asynchronous, active-low.
- n_wr  in  1  MSX write strobe, asynchronous, active-low.
- n_rd  in  1  MSX read strobe, asynchronous, active-low.
- ta  in  2  MSX port address (low bits).
- td_in  in  8  MSX data bus, input side.
- td_out  out  8  data driven to the MSX bus.
- td_oe  out  1  1 = drive td_out onto the MSX bus.
- tdir  out  1  level-shifter direction; 1 = FPGA to MSX.
- twait  out  1  1 = request MSX wait (inverted externally).
- bus_ioreq  out  1  internal request valid.
- bus_write  out  1  1 = write, 0 = read; valid while bus_ioreq=1.
- bus_address  out  2  latched ta.
- bus_wdata  out  8  latched td_in.
- bus_ready  in  1  request accepted when bus_ioreq and bus_ready are both 1.
- bus_rdata  in  8  read data.
- bus_rdata_en  in  1  one-cycle strobe qualifying bus_rdata.

Behaviour:
- Reset (async, n_reset=0):
  - All sync flops reset to 1.
  - State = IDLE.
  - td_out=0x00; td_oe, tdir, twait, bus_ioreq, bus_write = 0; bus_address=0; bus_wdata=0; timeout counter = 0.
  - A reset asserted mid-operation forces all of these values immediately, without waiting for a clock edge.
- Synchronisation:
  - s_ce, s_wr and s_rd are the last stage of a SYNC_STAGES flop chain.
  - ta and td_in are captured only at the moment a request is issued; they are not otherwise synchronised.
- IDLE:
  - If s_ce=0 and s_wr=0: latch ta and td_in, set bus_ioreq=1 and bus_write=1, go to WR_REQ.
  - Else if s_ce=0 and s_rd=0: latch ta, set bus_ioreq=1 and bus_write=0, set twait=1, go to RD_REQ.
  - If s_wr and s_rd are both 0, the write wins.
  - Latency: bus_ioreq rises SYNC_STAGES+1 clk edges after the MSX strobe falls.
- WR_REQ:
  - Hold bus_ioreq, bus_write, bus_address and bus_wdata stable until bus_ready=1.
  - On the accept edge: bus_ioreq=0, go to END_WAIT.
- RD_REQ:
  - Hold the request until bus_ready=1.
  - On the accept edge: bus_ioreq=0, clear the timeout counter, go to RD_WAIT.
- RD_WAIT:
  - On bus_rdata_en=1: td_out=bus_rdata, twait=0, go to RD_HOLD.
  - If the counter reaches RD_TIMEOUT first: td_out=0xFF, twait=0, go to RD_HOLD.
  - If bus_rdata_en and the timeout coincide, the data wins.
  - If s_ce or s_rd returned to 1 at any point before RD_HOLD (abandoned read): on data/timeout go to IDLE instead, with td_oe never asserted.
- RD_HOLD:
  - td_oe=1 and tdir=1 while s_ce=0 and s_rd=0.
  - When either strobe returns to 1: td_oe=0 and tdir=0 on the next edge, go to IDLE.
- END_WAIT:
  - Stay until s_ce=1, or until s_wr=1 and s_rd=1; then go to IDLE.
  - Guarantees exactly one request per MSX strobe, however long the strobe is held.
- Requests are never cancelled once issued; the handshake always completes.
- bus_rdata_en outside RD_WAIT is ignored.
- tdir=1 only in RD_HOLD, and td_oe implies tdir.

Optional Feature:
- Macro: MSX_CART_BUS_TWAIT_EN.
- Defined: twait behaves as described above (1 from read detection until data or timeout).
- Not defined: twait is constant 0. The state machine, timeout and 0xFF fallback are unchanged; the MSX relies on the access being fast enough.

Test Plan:
- Write, ta=1, td_in=0x5A, bus_ready tied 1 → single bus_ioreq pulse 3 cycles after n_wr falls (SYNC_STAGES=2), bus_address=1, bus_wdata=0x5A, bus_write=1; no second request while n_wr is held low for 40 more cycles.
- Write with bus_ready held 0 for 5 cycles → request fields stable for the whole stall, accepted exactly once, END_WAIT left only after n_wr rises.
- Read, ta=2, bus_rdata=0x3C with bus_rdata_en 4 cycles after accept → twait=1 from request to strobe (with MSX_CART_BUS_TWAIT_EN); td_out=0x3C; td_oe=tdir=1 until 3 cycles after n_rd rises.
- Read with no bus_rdata_en → exactly 63 cycles after accept td_out=0xFF and twait=0; td_oe=1 until n_rd rises.
- Read with n_ce released during RD_WAIT, then bus_rdata_en → td_oe and tdir never 1; state returns to IDLE; next write is accepted normally.
- n_reset pulsed low during RD_HOLD → td_oe, tdir, twait and bus_ioreq all 0 before the next clk edge; no request issued after reset until a new strobe edge.

Source files
------------

// File: rtl/msx_cart_bus_if_if.sv
// MSX cartridge pins plus internal I/O request bus.
// slave = cartridge front-end, master = MSX host and bus side.
`timescale 1ns/1ps
interface msx_cart_bus_if_if;
  logic       n_ce;
  logic       n_wr;
  logic       n_rd;
  logic [1:0] ta;
  logic [7:0] td_in;
  logic [7:0] td_out;
  logic       td_oe;
  logic       tdir;
  logic       twait;
  logic       bus_ioreq;
  logic       bus_write;
  logic [1:0] bus_address;
  logic [7:0] bus_wdata;
  logic       bus_ready;
  logic [7:0] bus_rdata;
  logic       bus_rdata_en;

  modport slave (
    input  n_ce, n_wr, n_rd, ta, td_in,
    output td_out, td_oe, tdir, twait,
    output bus_ioreq, bus_write,
    output bus_address, bus_wdata,
    input  bus_ready, bus_rdata, bus_rdata_en
  );

  modport master (
    output n_ce, n_wr, n_rd, ta, td_in,
    input  td_out, td_oe, tdir, twait,
    input  bus_ioreq, bus_write,
    input  bus_address, bus_wdata,
    output bus_ready, bus_rdata, bus_rdata_en
  );
endinterface

// File: rtl/msx_cart_bus_if.sv
// MSX cartridge slave front-end: strobe sync, one bus request
// per MSX I/O access, read data return and optional wait.
// Ports: clk, n_reset (async low), bus (msx_cart_bus_if_if.slave).
// Macro MSX_CART_BUS_TWAIT_EN enables the twait output.
`timescale 1ns/1ps
module msx_cart_bus_if #(
  parameter int SYNC_STAGES = 2,
  parameter int RD_TIMEOUT  = 63
) (
  input  logic                  clk,
  input  logic                  n_reset,
  msx_cart_bus_if_if.slave      bus
);

`ifdef MSX_CART_BUS_TWAIT_EN
  localparam bit TWAIT_EN = 1'b1;
`else
  localparam bit TWAIT_EN = 1'b0;
`endif

  localparam logic [7:0] TMO_LAST = 8'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_HOLD,
    S_END_WAIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SYNC_STAGES-1:0] r_ce_sync;
  logic [SYNC_STAGES-1:0] r_wr_sync;
  logic [SYNC_STAGES-1:0] r_rd_sync;

  logic [7:0] r_td_out, w_td_out_n;
  logic       r_td_oe,  w_td_oe_n;
  logic       r_tdir,   w_tdir_n;
  logic       r_twait,  w_twait_n;
  logic       r_ioreq,  w_ioreq_n;
  logic       r_write,  w_write_n;
  logic [1:0] r_addr,   w_addr_n;
  logic [7:0] r_wdata,  w_wdata_n;
  logic [7:0] r_cnt,    w_cnt_n;
  logic       r_abn,    w_abn_n;

  logic w_s_ce;
  logic w_s_wr;
  logic w_s_rd;
  logic w_wr_det;
  logic w_rd_det;
  logic w_rel;
  logic w_tmo;
  logic w_done;
  logic w_abn;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_ce_sync <= '1;
      r_wr_sync <= '1;
      r_rd_sync <= '1;
    end else begin
      r_ce_sync <= {r_ce_sync[SYNC_STAGES-2:0], bus.n_ce};
      r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], bus.n_wr};
      r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], bus.n_rd};
    end
  end

  assign w_s_ce   = r_ce_sync[SYNC_STAGES-1];
  assign w_s_wr   = r_wr_sync[SYNC_STAGES-1];
  assign w_s_rd   = r_rd_sync[SYNC_STAGES-1];
  // write has priority when both strobes are low
  assign w_wr_det = !w_s_ce && !w_s_wr;
  assign w_rd_det = !w_s_ce && !w_s_rd && w_s_wr;
  assign w_rel    = w_s_ce || w_s_rd;
  assign w_tmo    = (r_cnt == TMO_LAST);
  assign w_done   = bus.bus_rdata_en || w_tmo;
  // sticky: the read strobe went away before data arrived
  assign w_abn    = r_abn || w_rel;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state  <= S_IDLE;
      r_td_out <= 8'h00;
      r_td_oe  <= 1'b0;
      r_tdir   <= 1'b0;
      r_twait  <= 1'b0;
      r_ioreq  <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= 2'd0;
      r_wdata  <= 8'h00;
      r_cnt    <= 8'd0;
      r_abn    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_td_out <= w_td_out_n;
      r_td_oe  <= w_td_oe_n;
      r_tdir   <= w_tdir_n;
      r_twait  <= w_twait_n;
      r_ioreq  <= w_ioreq_n;
      r_write  <= w_write_n;
      r_addr   <= w_addr_n;
      r_wdata  <= w_wdata_n;
      r_cnt    <= w_cnt_n;
      r_abn    <= w_abn_n;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_wr_det)      w_next = S_WR_REQ;
        else if (w_rd_det) w_next = S_RD_REQ;
      end
      S_WR_REQ: begin
        if (bus.bus_ready) w_next = S_END_WAIT;
      end
      S_RD_REQ: begin
        if (bus.bus_ready) w_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (w_done)
          w_next = w_abn ? S_IDLE : S_RD_HOLD;
      end
      S_RD_HOLD: begin
        if (w_rel) w_next = S_IDLE;
      end
      S_END_WAIT: begin
        if (w_s_ce || (w_s_wr && w_s_rd))
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_td_out_n = r_td_out;
    w_td_oe_n  = r_td_oe;
    w_tdir_n   = r_tdir;
    w_twait_n  = r_twait;
    w_ioreq_n  = r_ioreq;
    w_write_n  = r_write;
    w_addr_n   = r_addr;
    w_wdata_n  = r_wdata;
    w_cnt_n    = r_cnt;
    w_abn_n    = r_abn;
    unique case (r_state)
      S_IDLE: begin
        w_abn_n = 1'b0;
        if (w_wr_det) begin
          w_addr_n  = bus.ta;
          w_wdata_n = bus.td_in;
          w_ioreq_n = 1'b1;
          w_write_n = 1'b1;
        end else if (w_rd_det) begin
          w_addr_n  = bus.ta;
          w_ioreq_n = 1'b1;
          w_write_n = 1'b0;
          w_twait_n = TWAIT_EN;
        end
      end
      S_WR_REQ: begin
        if (bus.bus_ready) w_ioreq_n = 1'b0;
      end
      S_RD_REQ: begin
        w_abn_n = w_abn;
        if (bus.bus_ready) begin
          w_ioreq_n = 1'b0;
          w_cnt_n   = 8'd0;
        end
      end
      S_RD_WAIT: begin
        w_abn_n = w_abn;
        if (w_done) begin
          // data beats a coincident timeout
          w_td_out_n = bus.bus_rdata_en ?
                       bus.bus_rdata : 8'hFF;
          w_twait_n  = 1'b0;
          w_td_oe_n  = !w_abn;
          w_tdir_n   = !w_abn;
        end else begin
          w_cnt_n = r_cnt + 8'd1;
        end
      end
      S_RD_HOLD: begin
        if (w_rel) begin
          w_td_oe_n = 1'b0;
          w_tdir_n  = 1'b0;
        end
      end
      S_END_WAIT: begin
        w_abn_n = 1'b0;
      end
      default: begin
        w_td_oe_n = 1'b0;
        w_tdir_n  = 1'b0;
        w_ioreq_n = 1'b0;
        w_twait_n = 1'b0;
      end
    endcase
  end

  assign bus.td_out      = r_td_out;
  assign bus.td_oe       = r_td_oe;
  assign bus.tdir        = r_tdir;
  assign bus.twait       = r_twait;
  assign bus.bus_ioreq   = r_ioreq;
  assign bus.bus_write   = r_write;
  assign bus.bus_address = r_addr;
  assign bus.bus_wdata   = r_wdata;

endmodule

// File: tb/tb_msx_cart_bus_if.sv
// Directed testbench for msx_cart_bus_if.
// Scenario tasks with inline checks, summary at end.
`timescale 1ns/1ps
module tb_msx_cart_bus_if;
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  msx_cart_bus_if_if bus();

  msx_cart_bus_if #(
    .SYNC_STAGES(2),
    .RD_TIMEOUT(63)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .bus(bus)
  );

`ifdef MSX_CART_BUS_TWAIT_EN
  localparam logic TW = 1'b1;
`else
  localparam logic TW = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int oe_cyc = 0;

  always @(posedge clk)
    if (bus.bus_ioreq && bus.bus_ready)
      acc_cnt <= acc_cnt + 1;

  always @(posedge clk)
    if (bus.td_oe || bus.tdir)
      oe_cyc <= oe_cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    tick(2);
    checks++;
    if ({bus.td_oe, bus.tdir, bus.twait,
         bus.bus_ioreq, bus.bus_write} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 00000",
        {bus.td_oe, bus.tdir, bus.twait,
         bus.bus_ioreq, bus.bus_write});
    end
    checks++;
    if ({bus.bus_address, bus.bus_wdata, bus.td_out}
        !== 18'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0",
        {bus.bus_address, bus.bus_wdata, bus.td_out});
    end
    n_reset = 1'b1;
    tick(3);
    bus.bus_rdata = 8'hAA;
    bus.bus_rdata_en = 1'b1;
    tick(1);
    bus.bus_rdata_en = 1'b0;
    tick(2);
    checks++;
    if (bus.td_out !== 8'h00 || bus.td_oe !== 1'b0) begin
      errors++;
      $display("FAIL idle_rdata_en: got %h/%b want 00/0",
        bus.td_out, bus.td_oe);
    end
  endtask

  task automatic test_write_single();
    int base;
    base = acc_cnt;
    bus.bus_ready = 1'b1;
    bus.ta = 2'd1;
    bus.td_in = 8'h5A;
    bus.n_ce = 1'b0;
    bus.n_wr = 1'b0;
    tick(2);
    checks++;
    if (bus.bus_ioreq !== 1'b0) begin
      errors++;
      $display("FAIL wr_early: ioreq got %b want 0",
        bus.bus_ioreq);
    end
    tick(1);
    checks++;
    if (bus.bus_ioreq !== 1'b1 || bus.bus_write !== 1'b1 ||
        bus.bus_address !== 2'd1 ||
        bus.bus_wdata !== 8'h5A) begin
      errors++;
      $display("FAIL wr_req: got %b%b %h %h want 11 1 5a",
        bus.bus_ioreq, bus.bus_write,
        bus.bus_address, bus.bus_wdata);
    end
    tick(1);
    checks++;
    if (bus.bus_ioreq !== 1'b0) begin
      errors++;
      $display("FAIL wr_drop: ioreq got %b want 0",
        bus.bus_ioreq);
    end
    tick(40);
    checks++;
    if (acc_cnt - base != 1) begin
      errors++;
      $display("FAIL wr_once: accepts got %0d want 1",
        acc_cnt - base);
    end
    bus.n_wr = 1'b1;
    bus.n_ce = 1'b1;
    tick(4);
  endtask

  task automatic test_write_stall();
    int base;
    int bad;
    base = acc_cnt;
    bad = 0;
    bus.bus_ready = 1'b0;
    bus.ta = 2'd3;
    bus.td_in = 8'hA5;
    bus.n_ce = 1'b0;
    bus.n_wr = 1'b0;
    tick(3);
    bus.td_in = 8'h00;
    for (int i = 0; i < 5; i++) begin
      if (bus.bus_ioreq !== 1'b1 || bus.bus_write !== 1'b1 ||
          bus.bus_address !== 2'd3 ||
          bus.bus_wdata !== 8'hA5)
        bad++;
      tick(1);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_stable: bad cycles got %0d want 0",
        bad);
    end
    bus.bus_ready = 1'b1;
    tick(1);
    checks++;
    if (bus.bus_ioreq !== 1'b0 || acc_cnt - base != 1) begin
      errors++;
      $display("FAIL stall_accept: got %b/%0d want 0/1",
        bus.bus_ioreq, acc_cnt - base);
    end
    tick(10);
    checks++;
    if (acc_cnt - base != 1) begin
      errors++;
      $display("FAIL stall_once: accepts got %0d want 1",
        acc_cnt - base);
    end
    bus.n_wr = 1'b1;
    tick(4);
    bus.td_in = 8'h66;
    bus.ta = 2'd2;
    bus.n_wr = 1'b0;
    tick(3);
    checks++;
    if (bus.bus_ioreq !== 1'b1 || bus.bus_wdata !== 8'h66) begin
      errors++;
      $display("FAIL end_wait_exit: got %b %h want 1 66",
        bus.bus_ioreq, bus.bus_wdata);
    end
    tick(1);
    checks++;
    if (acc_cnt - base != 2) begin
      errors++;
      $display("FAIL rewrite_accept: got %0d want 2",
        acc_cnt - base);
    end
    bus.n_wr = 1'b1;
    bus.n_ce = 1'b1;
    tick(4);
  endtask

  task automatic test_read_data();
    bus.bus_ready = 1'b1;
    bus.ta = 2'd2;
    bus.n_ce = 1'b0;
    bus.n_rd = 1'b0;
    tick(3);
    checks++;
    if (bus.bus_ioreq !== 1'b1 || bus.bus_write !== 1'b0 ||
        bus.bus_address !== 2'd2 || bus.twait !== TW) begin
      errors++;
      $display("FAIL rd_req: got %b%b %h tw%b want 10 2 tw%b",
        bus.bus_ioreq, bus.bus_write, bus.bus_address,
        bus.twait, TW);
    end
    tick(1);
    checks++;
    if (bus.bus_ioreq !== 1'b0 || bus.twait !== TW ||
        bus.td_oe !== 1'b0) begin
      errors++;
      $display("FAIL rd_wait: got %b %b %b want 0 %b 0",
        bus.bus_ioreq, bus.twait, bus.td_oe, TW);
    end
    tick(3);
    bus.bus_rdata = 8'h3C;
    bus.bus_rdata_en = 1'b1;
    tick(1);
    bus.bus_rdata_en = 1'b0;
    checks++;
    if (bus.td_out !== 8'h3C || bus.td_oe !== 1'b1 ||
        bus.tdir !== 1'b1 || bus.twait !== 1'b0) begin
      errors++;
      $display("FAIL rd_data: got %h %b%b%b want 3c 110",
        bus.td_out, bus.td_oe, bus.tdir, bus.twait);
    end
    tick(5);
    bus.n_rd = 1'b1;
    tick(2);
    checks++;
    if (bus.td_oe !== 1'b1 || bus.tdir !== 1'b1) begin
      errors++;
      $display("FAIL rd_hold: got %b%b want 11",
        bus.td_oe, bus.tdir);
    end
    tick(1);
    checks++;
    if (bus.td_oe !== 1'b0 || bus.tdir !== 1'b0) begin
      errors++;
      $display("FAIL rd_release: got %b%b want 00",
        bus.td_oe, bus.tdir);
    end
    bus.n_ce = 1'b1;
    tick(3);
  endtask

  task automatic test_read_timeout();
    bus.bus_ready = 1'b1;
    bus.ta = 2'd1;
    bus.n_ce = 1'b0;
    bus.n_rd = 1'b0;
    tick(4);
    tick(62);
    checks++;
    if (bus.td_oe !== 1'b0 || bus.td_out !== 8'h3C ||
        bus.twait !== TW) begin
      errors++;
      $display("FAIL tmo_early: got %b %h %b want 0 3c %b",
        bus.td_oe, bus.td_out, bus.twait, TW);
    end
    tick(1);
    checks++;
    if (bus.td_out !== 8'hFF || bus.twait !== 1'b0 ||
        bus.td_oe !== 1'b1) begin
      errors++;
      $display("FAIL tmo_fire: got %h %b %b want ff 0 1",
        bus.td_out, bus.twait, bus.td_oe);
    end
    tick(3);
    bus.n_rd = 1'b1;
    tick(3);
    checks++;
    if (bus.td_oe !== 1'b0) begin
      errors++;
      $display("FAIL tmo_release: td_oe got %b want 0",
        bus.td_oe);
    end
    bus.n_ce = 1'b1;
    tick(3);
  endtask

  task automatic test_read_abandon();
    int base_oe;
    int base;
    base_oe = oe_cyc;
    bus.bus_ready = 1'b1;
    bus.ta = 2'd3;
    bus.n_ce = 1'b0;
    bus.n_rd = 1'b0;
    tick(4);
    bus.n_ce = 1'b1;
    tick(4);
    bus.bus_rdata = 8'h77;
    bus.bus_rdata_en = 1'b1;
    tick(1);
    bus.bus_rdata_en = 1'b0;
    tick(3);
    bus.n_rd = 1'b1;
    checks++;
    if (oe_cyc - base_oe != 0 || bus.twait !== 1'b0 ||
        bus.bus_ioreq !== 1'b0) begin
      errors++;
      $display("FAIL abandon: oe %0d tw %b req %b want 0 0 0",
        oe_cyc - base_oe, bus.twait, bus.bus_ioreq);
    end
    tick(2);
    base = acc_cnt;
    bus.ta = 2'd0;
    bus.td_in = 8'hC3;
    bus.n_ce = 1'b0;
    bus.n_wr = 1'b0;
    tick(3);
    checks++;
    if (bus.bus_ioreq !== 1'b1 || bus.bus_write !== 1'b1 ||
        bus.bus_address !== 2'd0 ||
        bus.bus_wdata !== 8'hC3) begin
      errors++;
      $display("FAIL post_abandon_wr: got %b%b %h %h want 11 0 c3",
        bus.bus_ioreq, bus.bus_write,
        bus.bus_address, bus.bus_wdata);
    end
    tick(1);
    checks++;
    if (acc_cnt - base != 1) begin
      errors++;
      $display("FAIL post_abandon_acc: got %0d want 1",
        acc_cnt - base);
    end
    bus.n_wr = 1'b1;
    bus.n_ce = 1'b1;
    tick(4);
  endtask

  task automatic test_reset_mid();
    int reqs;
    bus.bus_ready = 1'b1;
    bus.ta = 2'd0;
    bus.n_ce = 1'b0;
    bus.n_rd = 1'b0;
    tick(4);
    bus.bus_rdata = 8'h11;
    bus.bus_rdata_en = 1'b1;
    tick(1);
    bus.bus_rdata_en = 1'b0;
    checks++;
    if (bus.td_oe !== 1'b1 || bus.td_out !== 8'h11) begin
      errors++;
      $display("FAIL pre_reset_hold: got %b %h want 1 11",
        bus.td_oe, bus.td_out);
    end
    #2;
    n_reset = 1'b0;
    #1;
    checks++;
    if ({bus.td_oe, bus.tdir, bus.twait, bus.bus_ioreq}
        !== 4'b0 || bus.td_out !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got %b %h want 0000 00",
        {bus.td_oe, bus.tdir, bus.twait, bus.bus_ioreq},
        bus.td_out);
    end
    bus.n_ce = 1'b1;
    bus.n_rd = 1'b1;
    tick(2);
    n_reset = 1'b1;
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.bus_ioreq !== 1'b0) reqs++;
    end
    checks++;
    if (reqs != 0) begin
      errors++;
      $display("FAIL post_reset_idle: req cycles %0d want 0",
        reqs);
    end
    bus.ta = 2'd2;
    bus.td_in = 8'h99;
    bus.n_ce = 1'b0;
    bus.n_wr = 1'b0;
    tick(3);
    checks++;
    if (bus.bus_ioreq !== 1'b1 || bus.bus_wdata !== 8'h99) begin
      errors++;
      $display("FAIL post_reset_wr: got %b %h want 1 99",
        bus.bus_ioreq, bus.bus_wdata);
    end
    bus.n_wr = 1'b1;
    bus.n_ce = 1'b1;
    tick(4);
  endtask

  initial begin
    bus.n_ce = 1'b1;
    bus.n_wr = 1'b1;
    bus.n_rd = 1'b1;
    bus.ta = 2'd0;
    bus.td_in = 8'h00;
    bus.bus_ready = 1'b0;
    bus.bus_rdata = 8'h00;
    bus.bus_rdata_en = 1'b0;
    test_reset();
    test_write_single();
    test_write_stall();
    test_read_data();
    test_read_timeout();
    test_read_abandon();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks",
      errors, checks);
    $finish;
  end
endmodule
